spd_avg_monitor: RTL and testbench

- Synthesizable, parametrised multi-channel speed monitor. It replaces the bench-only averaging and matching checks with a reusable block.
- Each run waits a programmable settle time, then averages 2^LOG2_SAMPLES samples per channel.
- While averaging, it flags any channel that deviates from channel 0 by more than a tolerance.
- Optionally reports each channel's trend against its previous average.
- Sits beside the balance controller on lft_spd/rght_spd, or wider wheel/motor speed buses, for on-chip self-test and debug.

---
 rtl/spd_avg_monitor.sv | 163 ++++++++++++++++
 tb/tb_spd_avg_monitor.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spd_avg_monitor.sv
// spd_avg_monitor: multi-channel speed monitor.
// Each run waits a programmable settle time, then averages 2^LOG2_SAMPLES
// accepted samples per channel. While averaging it flags any channel that
// deviates from channel 0 by more than tol.
// Optional feature macro: SPD_TREND_EN -- when defined, every completed run
// also reports per-channel trend_up/trend_dn against the previous run's
// average (tol used as dead-band); when undefined both trend outputs are 0.
module spd_avg_monitor #(
   parameter int NUM_CH       = 2,
   parameter int WIDTH        = 12,
   parameter int LOG2_SAMPLES = 10,
   parameter int SETTLE_W     = 20
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       sample_en,
   input  logic [NUM_CH*WIDTH-1:0]    spd,
   input  logic [WIDTH-1:0]           tol,
   input  logic [SETTLE_W-1:0]        settle,
   output logic                       busy,
   output logic                       avg_vld,
   output logic [NUM_CH*WIDTH-1:0]    avg,
   output logic                       mismatch,
   output logic [NUM_CH-1:0]          mis_ch,
   output logic [NUM_CH-1:0]          trend_up,
   output logic [NUM_CH-1:0]          trend_dn
);

   // Accumulator is wide enough to sum 2^LOG2_SAMPLES full-scale samples.
   localparam int AW = WIDTH + LOG2_SAMPLES;
   // Sample counter, one bit wider than needed to count the window.
   localparam int CW = LOG2_SAMPLES + 1;
   localparam logic [CW-1:0] LAST = {1'b0, {LOG2_SAMPLES{1'b1}}};

   typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_t;

   state_t                  state;
   logic [SETTLE_W-1:0]     cnt;
   logic [CW-1:0]           scnt;
   logic signed [AW-1:0]    acc     [NUM_CH];

   logic signed [WIDTH-1:0] smp     [NUM_CH];
   logic signed [AW-1:0]    acc_nxt [NUM_CH];
   logic signed [WIDTH-1:0] avg_nxt [NUM_CH];
   logic signed [WIDTH:0]   dif     [NUM_CH];
   logic [WIDTH:0]          mag     [NUM_CH];
   logic [NUM_CH-1:0]       dev;
   logic                    accept;
   logic                    last;

   // Unpack channels, form the running sums and the average they would give
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         smp[i]     = spd[i*WIDTH +: WIDTH];
         acc_nxt[i] = acc[i] + AW'(smp[i]);
         avg_nxt[i] = WIDTH'(acc_nxt[i] >>> LOG2_SAMPLES);
      end
   end

   // Deviation of every channel from channel 0, one bit wider so the
   // difference and its magnitude never wrap at full-scale extremes
   always_comb begin
      dev = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         dif[i] = {smp[i][WIDTH-1], smp[i]} - {smp[0][WIDTH-1], smp[0]};
         mag[i] = dif[i][WIDTH] ? -dif[i] : dif[i];
         if (i > 0) dev[i] = (mag[i] > {1'b0, tol});
      end
   end

   assign accept = (state == ACCUM) && sample_en;
   assign last   = accept && (scnt == LAST);

   // Run sequencing: settle countdown, accumulation, average capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         scnt     <= '0;
         busy     <= 1'b0;
         avg_vld  <= 1'b0;
         avg      <= '0;
         mismatch <= 1'b0;
         mis_ch   <= '0;
         for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      end else if (start) begin
         // A (re)start discards any partial run; avg keeps the last result.
         state    <= SETTLE;
         cnt      <= settle;
         scnt     <= '0;
         busy     <= 1'b1;
         avg_vld  <= 1'b0;
         mismatch <= 1'b0;
         mis_ch   <= '0;
         for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      end else begin
         avg_vld <= 1'b0;
         case (state)
            IDLE: ;
            SETTLE: begin
               if (cnt == '0) state <= ACCUM;
               else           cnt   <= cnt - SETTLE_W'(1);
            end
            ACCUM: begin
               if (accept) begin
                  for (int i = 0; i < NUM_CH; i++) acc[i] <= acc_nxt[i];
                  scnt   <= scnt + CW'(1);
                  mis_ch <= mis_ch | dev;
                  if (|dev) mismatch <= 1'b1;
                  // Average is registered on the last accepting edge so it is
                  // already valid during the DONE cycle alongside avg_vld.
                  if (scnt == LAST) begin
                     state   <= DONE;
                     busy    <= 1'b0;
                     avg_vld <= 1'b1;
                     for (int i = 0; i < NUM_CH; i++)
                        avg[i*WIDTH +: WIDTH] <= avg_nxt[i];
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SPD_TREND_EN
   logic signed [WIDTH-1:0] prev_avg [NUM_CH];
   logic                    prev_valid;
   logic signed [WIDTH:0]   tdif     [NUM_CH];
   logic signed [WIDTH:0]   band;

   assign band = $signed({1'b0, tol});

   // Change of each new average against the previous run, without wrap
   always_comb begin
      for (int i = 0; i < NUM_CH; i++)
         tdif[i] = {avg_nxt[i][WIDTH-1], avg_nxt[i]} - {prev_avg[i][WIDTH-1], prev_avg[i]};
   end

   // On each completed run, grade the trend and remember the new average
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_valid <= 1'b0;
         trend_up   <= '0;
         trend_dn   <= '0;
         for (int i = 0; i < NUM_CH; i++) prev_avg[i] <= '0;
      end else if (last && !start) begin
         prev_valid <= 1'b1;
         for (int i = 0; i < NUM_CH; i++) begin
            prev_avg[i] <= avg_nxt[i];
            trend_up[i] <= prev_valid && (tdif[i] > band);
            trend_dn[i] <= prev_valid && (tdif[i] < -band);
         end
      end
   end
`else
   assign trend_up = '0;
   assign trend_dn = '0;
`endif

endmodule

// File: tb/tb_spd_avg_monitor.sv
// tb_spd_avg_monitor: randomized + directed bench for spd_avg_monitor with a
// run-level reference model (sample sums, floor division, |difference| check).
module tb_spd_avg_monitor;
   localparam int NC = 2;
   localparam int W  = 12;
   localparam int L  = 4;
   localparam int SW = 8;
   localparam int NS = 16;
   localparam int M_CONST = 0, M_ALT = 1, M_SPIKE = 2, M_SETTLE = 3, M_RAND = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          sample_en = 1'b0;
   logic [NC*W-1:0] spd = '0;
   logic [W-1:0]  tol = '0;
   logic [SW-1:0] settle = '0;
   logic          busy, avg_vld, mismatch;
   logic [NC*W-1:0] avg;
   logic [NC-1:0] mis_ch, trend_up, trend_dn;

   int checks = 0, errors = 0;
   int mode = 0, en_mode = 0, k_cyc = 0, base0 = 0, off1 = 0, spike_k = -1, set_v = 0;
   int cur0 = 0, cur1 = 0;

   // reference model state
   int m_settle_left, m_n;
   bit m_collect;
   int m_sum [2];
`ifdef SPD_TREND_EN
   int m_prev [2];
   bit m_prev_ok;
`endif
   int e_busy, e_vld, e_mis, e_misch, e_up, e_dn;
   int e_avg [2];

   spd_avg_monitor #(.NUM_CH(NC), .WIDTH(W), .LOG2_SAMPLES(L), .SETTLE_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sample_en(sample_en), .spd(spd),
      .tol(tol), .settle(settle), .busy(busy), .avg_vld(avg_vld), .avg(avg),
      .mismatch(mismatch), .mis_ch(mis_ch), .trend_up(trend_up), .trend_dn(trend_dn)
   );

   always #5 clk = ~clk;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // floor(a / b) for b > 0
   function automatic int fdiv(input int a, input int b);
      return (a >= 0) ? a / b : -((-a + b - 1) / b);
   endfunction

   function automatic int a0();
      return int'($signed(avg[W-1:0]));
   endfunction

   function automatic int a1();
      return int'($signed(avg[2*W-1:W]));
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_settle_left = -1; m_n = 0; m_collect = 1'b0;
      m_sum[0] = 0; m_sum[1] = 0;
`ifdef SPD_TREND_EN
      m_prev[0] = 0; m_prev[1] = 0; m_prev_ok = 1'b0;
`endif
      e_busy = 0; e_vld = 0; e_mis = 0; e_misch = 0; e_up = 0; e_dn = 0;
      e_avg[0] = 0; e_avg[1] = 0;
   endtask

   // Advance the model by one clock edge using the inputs presented to it
   task automatic model_clock();
      int a;
      int up, dn;
      if (!rst_n) begin
         model_reset();
         return;
      end
      e_vld = 0;
      if (start) begin
         m_settle_left = int'(settle);
         m_collect = 1'b0; m_n = 0; m_sum[0] = 0; m_sum[1] = 0;
         e_mis = 0; e_misch = 0;
      end else if (m_settle_left > 0) begin
         m_settle_left--;
      end else if (m_settle_left == 0) begin
         m_settle_left = -1;
         m_collect = 1'b1;
      end else if (m_collect && sample_en) begin
         m_sum[0] += cur0; m_sum[1] += cur1; m_n++;
         if (iabs(cur1 - cur0) > int'(tol)) begin
            e_mis = 1; e_misch = 2;
         end
         if (m_n == NS) begin
            m_collect = 1'b0;
            e_vld = 1;
            up = 0; dn = 0;
            for (int c = 0; c < 2; c++) begin
               a = fdiv(m_sum[c], NS);
`ifdef SPD_TREND_EN
               if (m_prev_ok && (a - m_prev[c] > int'(tol))) up |= (1 << c);
               if (m_prev_ok && (m_prev[c] - a > int'(tol))) dn |= (1 << c);
               m_prev[c] = a;
`endif
               e_avg[c] = a;
            end
`ifdef SPD_TREND_EN
            m_prev_ok = 1'b1;
            e_up = up; e_dn = dn;
`endif
         end
      end
      e_busy = (m_settle_left >= 0 || m_collect) ? 1 : 0;
   endtask

   task automatic compare_all();
      chk("busy",     int'(busy),     e_busy);
      chk("avg_vld",  int'(avg_vld),  e_vld);
      chk("avg0",     a0(),           e_avg[0]);
      chk("avg1",     a1(),           e_avg[1]);
      chk("mismatch", int'(mismatch), e_mis);
      chk("mis_ch",   int'(mis_ch),   e_misch);
      chk("trend_up", int'(trend_up), e_up);
      chk("trend_dn", int'(trend_dn), e_dn);
   endtask

   // One clock: DUT and model both see the edge, outputs checked mid-cycle
   task automatic cyc();
      @(posedge clk);
      model_clock();
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_inputs();
      int c0, c1;
      start = 1'b0;
      c0 = base0;
      c1 = base0 + off1;
      case (mode)
         M_ALT:    begin c0 = (k_cyc % 2 == 0) ? -1 : 0; c1 = 0; end
         M_SPIKE:  c1 = (k_cyc == spike_k) ? base0 + off1 : base0;
         M_SETTLE: begin c0 = (k_cyc <= set_v) ? 1000 : 50; c1 = c0; end
         M_RAND: begin
            if ($urandom_range(0, 15) == 0) begin
               if ($urandom_range(0, 1) == 0) begin c0 = -2048; c1 = 2047; end
               else begin c0 = 2047; c1 = -2048; end
            end else begin
               c0 = $urandom_range(0, 3600) - 1800;
               c1 = c0 + $urandom_range(0, 60) - 30;
            end
            start = ($urandom_range(0, 79) == 0);
         end
         default: ;
      endcase
      if (en_mode == 0)      sample_en = 1'b1;
      else if (en_mode == 1) sample_en = (k_cyc % 2 == 0);
      else                   sample_en = 1'($urandom_range(0, 1));
      cur0 = c0;
      cur1 = c1;
      spd = {c1[W-1:0], c0[W-1:0]};
   endtask

   task automatic begin_run(input int s);
      settle = SW'(s);
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic step(input int k);
      k_cyc = k;
      set_inputs();
      cyc();
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      sample_en = 1'b0;
      repeat (n) cyc();
   endtask

   // Start a run and follow it until avg_vld (bounded); k=0 is the first
   // cycle after the start edge.
   task automatic run(input int s, output int bc, output int va);
      bc = 0;
      va = -1;
      begin_run(s);
      for (int k = 0; k < 200; k++) begin
         if (busy) bc++;
         if (avg_vld) begin
            va = k;
            break;
         end
         step(k);
      end
      start = 1'b0;
   endtask

   initial begin
      int bc, va, nv;
      int tr_avg [4];
      int tr_up  [4];
      int tr_dn  [4];
      tr_avg = '{100, 200, 205, 50};
`ifdef SPD_TREND_EN
      tr_up = '{0, 3, 0, 0};
      tr_dn = '{0, 0, 0, 3};
`else
      tr_up = '{0, 0, 0, 0};
      tr_dn = '{0, 0, 0, 0};
`endif
      model_reset();
      repeat (2) cyc();
      chk("rst_busy", int'(busy), 0);
      chk("rst_avg", int'(avg), 0);
      chk("rst_mis_ch", int'(mis_ch), 0);
      rst_n = 1'b1;

      // constant 100 on both channels
      tol = 12'd10; mode = M_CONST; base0 = 100; off1 = 0; en_mode = 0;
      run(0, bc, va);
      chk("t1_busy_cycles", bc, 17);
      chk("t1_vld_cycle", va, 17);
      chk("t1_avg0", a0(), 100);
      chk("t1_avg1", a1(), 100);
      chk("t1_mismatch", int'(mismatch), 0);

      // floor averaging of negatives (started in the DONE cycle)
      mode = M_ALT;
      run(0, bc, va);
      chk("t2_alt_vld", va, 17);
      chk("t2_alt_avg0", a0(), -1);
      chk("t2_alt_avg1", a1(), 0);
      mode = M_CONST; base0 = -3; off1 = 0;
      run(0, bc, va);
      chk("t2_neg3_avg0", a0(), -3);

      // tolerance boundary
      mode = M_SPIKE; base0 = 300; spike_k = 5; off1 = 11;
      run(0, bc, va);
      chk("t3_p11_mis", int'(mismatch), 1);
      chk("t3_p11_misch", int'(mis_ch), 2);
      idle(2);
      chk("t3_p11_hold_mis", int'(mismatch), 1);
      chk("t3_p11_hold_misch", int'(mis_ch), 2);
      off1 = 10;
      run(0, bc, va);
      chk("t3_p10_mis", int'(mismatch), 0);
      off1 = -10;
      run(0, bc, va);
      chk("t3_m10_mis", int'(mismatch), 0);
      off1 = -11;
      run(0, bc, va);
      chk("t3_m11_misch", int'(mis_ch), 2);
      off1 = 11; spike_k = 0;
      run(0, bc, va);
      chk("t3_settle_mis", int'(mismatch), 0);

      // settle samples ignored, and sample_en stalls
      mode = M_SETTLE; set_v = 5;
      run(5, bc, va);
      chk("t4_settle_vld", va, 22);
      chk("t4_settle_avg0", a0(), 50);
      chk("t4_settle_avg1", a1(), 50);
      mode = M_CONST; base0 = 7; off1 = 0; en_mode = 1;
      run(0, bc, va);
      chk("t4_toggle_vld", va, 33);
      chk("t4_toggle_busy", bc, 33);
      en_mode = 0;

      // restart discards the partial run
      idle(1);
      mode = M_CONST; base0 = 500; off1 = 0; nv = 0;
      begin_run(0);
      for (int k = 0; k <= 8; k++) begin
         step(k);
         if (avg_vld) nv++;
      end
      chk("t5_partial_no_vld", nv, 0);
      base0 = 20;
      run(0, bc, va);
      chk("t5_restart_vld", va, 17);
      chk("t5_restart_avg0", a0(), 20);

      // asynchronous reset in the middle of ACCUM
      mode = M_SPIKE; base0 = 40; off1 = 11; spike_k = 2; tol = 12'd10;
      begin_run(0);
      for (int k = 0; k <= 5; k++) step(k);
      chk("t6_pre_mis", int'(mismatch), 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_avg", int'(avg), 0);
      chk("t6_rst_mis", int'(mismatch), 0);
      chk("t6_rst_misch", int'(mis_ch), 0);
      chk("t6_rst_vld", int'(avg_vld), 0);
      model_reset();
      cyc();
      rst_n = 1'b1;
      idle(1);

      // trend sequence 100, 200, 205, 50 with tol 10
      tol = 12'd10; mode = M_CONST; off1 = 0; en_mode = 0;
      for (int r = 0; r < 4; r++) begin
         base0 = tr_avg[r];
         run(0, bc, va);
         chk("t7_trend_avg", a0(), tr_avg[r]);
         chk("t7_trend_up", int'(trend_up), tr_up[r]);
         chk("t7_trend_dn", int'(trend_dn), tr_dn[r]);
      end

      // randomized runs, checked cycle by cycle against the model
      mode = M_RAND;
      for (int r = 0; r < 150; r++) begin
         tol = 12'($urandom_range(0, 40));
         en_mode = $urandom_range(0, 2);
         run($urandom_range(0, 7), bc, va);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
